slink_rx_deskew_mk2: RTL
========================

Name: slink_rx_deskew_mk2

Overview:
Second-generation multi-lane RX deskew block. It sits between the per-lane RX datapaths (after the byte aligner) and the link-layer TS/SDS detection. Each lane has a programmable-depth delay line. During training the block finds a run-time-programmable alignment symbol on every active lane, locks per-lane read pointers, and keeps watching alignment while locked. It adds a training timeout with skew-error reporting and an automatic re-train after repeated misalignment.

Parameters:
NUM_LANES, 4, number of physical lanes (1..8).
DATA_WIDTH, 8, bits per lane per cycle.
FIFO_DEPTH, 8, delay-line entries per lane (2..16); maximum correctable skew is FIFO_DEPTH-1 cycles.
PTR_W, $clog2(FIFO_DEPTH), read-pointer width.
TRAIN_TIMEOUT, 1024, TRAIN cycles without lock before the block declares a skew error.
MISALIGN_LIMIT, 4, consecutive misaligned alignment-symbol events in LOCKED that trigger a re-train.

Ports:
clk  in  1  block clock.
reset  in  1  asynchronous active-high reset.
enable  in  1  deskew enable; low forces IDLE.
active_lanes  in  3  active lane count = 1<<active_lanes; lanes at or above this count are inactive.
align_symbol  in  DATA_WIDTH  alignment (COM) pattern; must be held static while enable=1.
rx_data_in  in  NUM_LANES*DATA_WIDTH  per-lane input data, lane i at [i*DATA_WIDTH +: DATA_WIDTH].
rx_data_valid  in  NUM_LANES  per-lane input valid.
rx_data_out  out  NUM_LANES*DATA_WIDTH  deskewed data; 0 on inactive lanes.
rx_data_valid_out  out  NUM_LANES  deskewed valid; 0 on inactive lanes.
fifo_ptr_status  out  NUM_LANES*PTR_W  current read pointer per lane; 0 on inactive lanes.
deskew_state  out  2  0=IDLE, 1=TRAIN, 2=LOCKED, 3=ERROR.
skew_error  out  1  high while in ERROR.
relock_pulse  out  1  one-cycle pulse on each LOCKED->TRAIN transition.

Behaviour:
- Reset: all delay-line entries, pointers, counters and the state go to 0/IDLE. All outputs are 0.
- Delay line per lane: entry0 <= {rx_data_valid[i], lane data}; entry k <= entry k-1 every cycle. Entries load 0 when enable=0 or the lane is inactive.
- Output: lane i drives entry[ptr_i]. Latency from input to output is ptr_i+1 cycles. Outputs are combinational from the registers.
- Match: match_i[k] = entry k valid && data == align_symbol. cand_i = the lowest k with match_i[k]=1 (the most recent one). hit_i = |match_i. Inactive lanes count as hit with cand=0.
- State IDLE: pointers are held at 0. If enable=1, go to TRAIN next cycle.
- State TRAIN:
  - Lock condition: all hit_i=1 AND at least one active lane has cand_i=0.
  - When the lock condition holds: ptr_i <= cand_i, go to LOCKED.
  - Otherwise pointers keep their value.
  - The timeout counter increments every TRAIN cycle. At TRAIN_TIMEOUT-1 without lock, go to ERROR.
  - The counter clears on entry to TRAIN.
- State LOCKED:
  - Pointers are frozen.
  - Per cycle, out_com_i = rx_data_valid_out[i] && rx_data_out lane i == align_symbol, evaluated over active lanes only.
  - All active lanes out_com: the misalign counter clears.
  - Some but not all active lanes out_com: the misalign counter increments.
  - When the counter would reach MISALIGN_LIMIT: go to TRAIN, pulse relock_pulse for one cycle, clear the counter.
  - Pointers are recaptured only at the next lock.
- State ERROR: sticky. skew_error=1. Pointers are held. The block leaves ERROR only when enable drops.
- enable=0 in any state: next state is IDLE, and the pointers and all counters clear next cycle.
- active_lanes must change only while enable=0. A change at any other time is undefined, but the block must not hang: enable low recovers it.
- Simultaneous events: in TRAIN, a lock condition on the same cycle as the timeout takes LOCKED. In LOCKED, enable=0 wins over re-train.
- Counter widths: timeout counter is $clog2(TRAIN_TIMEOUT+1) bits. Misalign counter is $clog2(MISALIGN_LIMIT+1) bits, saturating.

Test Plan:
1. 4 lanes, DATA_WIDTH=8, align_symbol=0xBC. Lanes carry a COM every 16 cycles, skews 0/1/3/5 cycles (lane 3 is the latest). -> LOCKED. fifo_ptr_status lanes = 5,4,2,0. The COM appears on all rx_data_out lanes in the same cycle.
2. Same traffic with lane 1 skew = FIFO_DEPTH (8). -> No lock. deskew_state=3 and skew_error=1 after 1024 TRAIN cycles. Dropping enable returns to IDLE with outputs 0.
3. From LOCKED, shift lane 2 by one extra cycle. -> 4 consecutive misaligned COM events. relock_pulse for one cycle, state=1, then re-lock with lane 2 pointer changed by 1.
4. active_lanes=1 (2 lanes), lanes 2-3 driven with garbage. -> Lock uses lanes 0-1 only. Outputs and pointers for lanes 2-3 stay 0.
5. Assert reset mid-LOCKED and also drop enable mid-TRAIN. -> Reset: state=0, all outputs 0 immediately. enable drop: state=0 next cycle, and re-training after enable returns reaches the same pointers as before.
6. A single misaligned COM event followed by an aligned one, repeated 10 times. -> The misalign counter never exceeds 1, and the block stays LOCKED with no relock_pulse.

Source files
------------

// File: rtl/slink_rx_deskew_mk2.sv
// slink_rx_deskew_mk2
// Multi-lane RX deskew. Each lane feeds a shift-register delay line. During
// TRAIN the block looks for the alignment symbol on every active lane and
// locks each lane's read pointer so that all lanes present the symbol in
// the same cycle. While LOCKED it watches the deskewed outputs and re-trains
// after repeated misalignment. A training timeout parks the block in ERROR
// until enable drops.
module slink_rx_deskew_mk2 #(
    parameter int NUM_LANES      = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int PTR_W          = $clog2(FIFO_DEPTH),
    parameter int TRAIN_TIMEOUT  = 1024,
    parameter int MISALIGN_LIMIT = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [2:0]                      active_lanes,
    input  logic [DATA_WIDTH-1:0]           align_symbol,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] rx_data_in,
    input  logic [NUM_LANES-1:0]            rx_data_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0] rx_data_out,
    output logic [NUM_LANES-1:0]            rx_data_valid_out,
    output logic [NUM_LANES*PTR_W-1:0]      fifo_ptr_status,
    output logic [1:0]                      deskew_state,
    output logic                            skew_error,
    output logic                            relock_pulse
);

    localparam int TO_W  = $clog2(TRAIN_TIMEOUT + 1);
    localparam int MIS_W = $clog2(MISALIGN_LIMIT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TRAIN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TRAIN_TIMEOUT - 1);
    localparam logic [MIS_W-1:0] MIS_LAST = MIS_W'(MISALIGN_LIMIT - 1);

    // Delay line entries hold {valid, data}; index 0 is the newest sample.
    logic [DATA_WIDTH:0]     dl_q [NUM_LANES][FIFO_DEPTH];

    logic [PTR_W-1:0]        ptr_q [NUM_LANES];
    logic [PTR_W-1:0]        ptr_d [NUM_LANES];
    logic [1:0]              state_q;
    logic [1:0]              state_d;
    logic [TO_W-1:0]         to_cnt_q;
    logic [TO_W-1:0]         to_cnt_d;
    logic [MIS_W-1:0]        mis_cnt_q;
    logic [MIS_W-1:0]        mis_cnt_d;
    logic                    relock_q;
    logic                    relock_d;

    logic [8:0]              lane_cnt_s;
    logic [NUM_LANES-1:0]    lane_act_s;
    logic [FIFO_DEPTH-1:0]   match_s [NUM_LANES];
    logic [PTR_W-1:0]        cand_s  [NUM_LANES];
    logic [NUM_LANES-1:0]    hit_s;
    logic [NUM_LANES-1:0]    cand_zero_s;
    logic [NUM_LANES-1:0]    out_com_s;
    logic                    lock_s;
    logic                    all_com_s;
    logic                    any_com_s;

    // Decode the active lane count into a per-lane enable mask.
    always_comb begin
        lane_cnt_s = 9'd1 << active_lanes;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_act_s[i] = (9'(i) < lane_cnt_s);
        end
    end

    // Shift each lane's delay line; idle or inactive lanes are flushed to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                for (int k = 0; k < FIFO_DEPTH; k++) begin
                    dl_q[i][k] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (!enable || !lane_act_s[i]) begin
                    for (int k = 0; k < FIFO_DEPTH; k++) begin
                        dl_q[i][k] <= '0;
                    end
                end else begin
                    dl_q[i][0] <= {rx_data_valid[i], rx_data_in[i*DATA_WIDTH +: DATA_WIDTH]};
                    for (int k = 1; k < FIFO_DEPTH; k++) begin
                        dl_q[i][k] <= dl_q[i][k-1];
                    end
                end
            end
        end
    end

    // Flag every delay-line entry holding a valid alignment symbol.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                match_s[i][k] = dl_q[i][k][DATA_WIDTH] &&
                                (dl_q[i][k][DATA_WIDTH-1:0] == align_symbol);
            end
        end
    end

    // Pick the most recent symbol per lane; inactive lanes never block a lock.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            hit_s[i]  = 1'b0;
            cand_s[i] = '0;
            for (int k = FIFO_DEPTH - 1; k >= 0; k--) begin
                cand_s[i] = match_s[i][k] ? PTR_W'(k) : cand_s[i];
                hit_s[i]  = hit_s[i] | match_s[i][k];
            end
            if (!lane_act_s[i]) begin
                hit_s[i]  = 1'b1;
                cand_s[i] = '0;
            end else begin
                cand_s[i] = cand_s[i];
            end
            cand_zero_s[i] = (cand_s[i] == '0);
        end
        // The symbol just arrived on the latest lane: every lane now holds it.
        lock_s = (&hit_s) && (|(lane_act_s & hit_s & cand_zero_s));
    end

    // Present each active lane's selected entry; inactive lanes read as zero.
    always_comb begin
        rx_data_out       = '0;
        rx_data_valid_out = '0;
        fifo_ptr_status   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_act_s[i]) begin
                rx_data_out[i*DATA_WIDTH +: DATA_WIDTH] = dl_q[i][ptr_q[i]][DATA_WIDTH-1:0];
                rx_data_valid_out[i]                    = dl_q[i][ptr_q[i]][DATA_WIDTH];
                fifo_ptr_status[i*PTR_W +: PTR_W]       = ptr_q[i];
            end else begin
                rx_data_out[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                rx_data_valid_out[i]                    = 1'b0;
                fifo_ptr_status[i*PTR_W +: PTR_W]       = '0;
            end
        end
    end

    // Watch the deskewed outputs for the alignment symbol on active lanes.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            out_com_s[i] = lane_act_s[i] && rx_data_valid_out[i] &&
                           (rx_data_out[i*DATA_WIDTH +: DATA_WIDTH] == align_symbol);
        end
        all_com_s = ((out_com_s & lane_act_s) == lane_act_s);
        any_com_s = |out_com_s;
    end

    // Training / lock state machine with timeout and misalign counters.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        mis_cnt_d = mis_cnt_q;
        relock_d  = 1'b0;
        ptr_d     = ptr_q;
        if (!enable) begin
            state_d   = ST_IDLE;
            to_cnt_d  = '0;
            mis_cnt_d = '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                ptr_d[i] = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_TRAIN;
                    to_cnt_d  = '0;
                    mis_cnt_d = '0;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        ptr_d[i] = '0;
                    end
                end
                ST_TRAIN: begin
                    // A lock on the timeout cycle still wins.
                    if (lock_s) begin
                        state_d   = ST_LOCKED;
                        mis_cnt_d = '0;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            ptr_d[i] = cand_s[i];
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d = ST_ERROR;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (all_com_s) begin
                        mis_cnt_d = '0;
                    end else if (any_com_s) begin
                        if (mis_cnt_q >= MIS_LAST) begin
                            state_d   = ST_TRAIN;
                            relock_d  = 1'b1;
                            mis_cnt_d = '0;
                            to_cnt_d  = '0;
                        end else begin
                            mis_cnt_d = mis_cnt_q + MIS_W'(1);
                        end
                    end else begin
                        mis_cnt_d = mis_cnt_q;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            to_cnt_q  <= '0;
            mis_cnt_q <= '0;
            relock_q  <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            relock_q  <= relock_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
        end
    end

    assign deskew_state = state_q;
    assign skew_error   = (state_q == ST_ERROR);
    assign relock_pulse = relock_q;

endmodule
